// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and link buffer depth, used by the input
// buffers and the upstream credit counters.
package noc_pkg;

    localparam int unsigned FLIT_W    = 34;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        SINGLE = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t             ftype;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    function automatic flit_t make_flit(input flit_type_t ftype,
                                        input logic [PAYLOAD_W-1:0] payload);
        flit_t f;
        f.ftype   = ftype;
        f.payload = payload;
        return f;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit store with read/write pointers and occupancy count.
// Caller guarantees no write when full (unless reading) and no read when empty.
module flit_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = FLIT_W,
    parameter int unsigned DEPTH  = BUF_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage array carries no reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en_i) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (rd_en_i) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data_o = r_mem[r_rd_ptr];
    assign count_o   = r_count;
    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/input_buffer_credit.sv
// Router input-port buffer on the credit link: stores upstream flits, presents the
// head flit, returns one credit per dequeue. EMPTY_BYPASS_EN enables empty bypass.
module input_buffer_credit
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = FLIT_W,
    parameter int unsigned DEPTH  = BUF_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] flit_i,
    input  logic              flit_valid_i,
    output logic [DATA_W-1:0] flit_o,
    output logic              flit_valid_o,
    input  logic              pop_i,
    output logic              credit_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);

    logic [DATA_W-1:0] w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_eff;
    logic              w_fifo_wr;
    logic              w_fifo_rd;
    logic              r_credit;
    logic              r_overflow;

    assign w_pop_eff = pop_i & flit_valid_o;

`ifdef EMPTY_BYPASS_EN
    logic w_bypass;

    // An arriving flit on an empty buffer is shown directly; if consumed at once it is never stored.
    assign w_bypass     = w_empty & flit_valid_i;
    assign flit_o       = w_bypass ? flit_i : w_head;
    assign flit_valid_o = ~w_empty | flit_valid_i;
    assign w_fifo_wr    = flit_valid_i & ~(w_bypass & pop_i) & (~w_full | w_pop_eff);
    assign w_fifo_rd    = w_pop_eff & ~w_bypass;
`else
    assign flit_o       = w_head;
    assign flit_valid_o = ~w_empty;
    assign w_fifo_wr    = flit_valid_i & (~w_full | w_pop_eff);
    assign w_fifo_rd    = w_pop_eff;
`endif

    flit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_fifo_wr),
        .wr_data_i (flit_i),
        .rd_en_i   (w_fifo_rd),
        .rd_data_o (w_head),
        .count_o   (count_o),
        .empty_o   (w_empty),
        .full_o    (w_full)
    );

    // Credit pulse follows each effective pop; overflow is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_pop_eff;
            if (flit_valid_i & w_full & ~w_pop_eff) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign credit_o   = r_credit;
    assign overflow_o = r_overflow;

endmodule

// File: doc/input_buffer_credit.md
Name: input_buffer_credit

Overview:
- Receive-side end of the router-to-router credit link. Sits at each router input port.
- Stores flits sent by the upstream router, which transmits only while it holds credits.
- Presents the head flit to the local switch/route logic.
- Returns one credit pulse upstream for every flit dequeued, so the upstream credit count always matches free slots here.

Parameters:
- DATA_W, 34, flit width (2-bit type plus 32-bit payload).
- DEPTH, 4, buffer slots. Must equal the upstream initial credit count. Power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flit_i  in  DATA_W  incoming flit from the upstream router.
- flit_valid_i  in  1  flit_i valid this cycle; writes one flit.
- flit_o  out  DATA_W  head-of-buffer flit.
- flit_valid_o  out  1  buffer non-empty (or bypass active, see Optional Feature).
- pop_i  in  1  local logic consumes flit_o this cycle.
- credit_o  out  1  one-cycle credit-return pulse to the upstream credit counter.
- count_o  out  CNT_W  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - read/write pointers = 0, count_o = 0.
  - flit_valid_o = 0, credit_o = 0, overflow_o = 0.
  - flit_o is don't-care.
- Reset mid-operation: buffered flits are discarded and any pending credit pulse is cancelled. The upstream counter shares rst and restarts at DEPTH credits.
- Storage: circular buffer of DEPTH entries; pointers wrap modulo DEPTH.
- Write: flit_valid_i=1 and (count<DEPTH or effective pop) → store at wr_ptr, wr_ptr+1.
- Effective pop: pop_i=1 and flit_valid_o=1. It advances rd_ptr. pop_i while empty is ignored and returns no credit.
- flit_o = mem[rd_ptr]. It is valid one cycle after the write (registered store), unless bypass is enabled.
- Count update:
  - write only → +1.
  - effective pop only → -1.
  - both in the same cycle → unchanged.
- Full with simultaneous write and pop: the write is accepted.
- Full with write and no pop: the flit is dropped, overflow_o is set to 1 and stays 1 until rst, and count stays DEPTH.
- Credit return:
  - credit_o is registered.
  - credit_o = 1 exactly one cycle after each effective pop.
  - Back-to-back pops give back-to-back pulses.
  - Credits returned never exceed flits accepted.
- Latency: write to flit_valid_o is 1 cycle; pop to credit_o is 1 cycle.
- Invariant: count_o + outstanding upstream credits + credits in flight = DEPTH.

Optional Feature:
- Macro: EMPTY_BYPASS_EN.
- Defined:
  - When count=0 and flit_valid_i=1, flit_o = flit_i and flit_valid_o = 1 in the same cycle.
  - If pop_i=1 in that cycle, the flit is consumed without being stored: count stays 0 and credit_o pulses the next cycle.
  - If pop_i=0, the flit is stored normally.
- Undefined: no combinational path from flit_i to flit_o. Minimum latency is 1 cycle.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W = 34, PAYLOAD_W = 32.
  - flit_type_t enum {HEAD, BODY, TAIL, SINGLE} in bits [33:32].
  - flit_t packed struct.
  - BUF_DEPTH = 4, used by both this block and the upstream credit counter.
- One sub-module: flit_fifo, containing the storage array, pointers and count.
- Credit-pulse register, overflow flag and bypass mux stay at top level.

Test Plan:
- Reset, then write 4 flits (0x0AAAA0001..0x0AAAA0004) on consecutive cycles with no pop → count_o=4, flit_o=first flit, credit_o stays 0.
- From full, pop 4 times back-to-back → flits come out in order, credit_o=1 on 4 consecutive cycles each one cycle after its pop, count_o ends at 0, flit_valid_o=0.
- At count=4, write and pop in the same cycle → write accepted, count_o stays 4, one credit pulse, overflow_o=0.
- At count=4, write with no pop → flit dropped, overflow_o=1 and it remains 1 after subsequent pops until rst.
- Pop with buffer empty → no state change, credit_o stays 0. Assert rst with 3 flits held and a credit pulse pending → count_o=0, credit_o=0 immediately.
- With EMPTY_BYPASS_EN: empty buffer, write 0x100000005 with pop → flit_o=0x100000005 the same cycle, count_o stays 0, credit_o=1 the next cycle. Without the macro, flit_valid_o rises one cycle after the write.
